icache_assoc: RTL

Parametrised set-associative instruction cache that replaces the fixed direct-mapped icache inside the per-CPU cache wrapper. It serves datapath fetches through the imemREN/imemaddr/ihit/imemload handshake and fills lines from the memory controller through the iREN/iaddr/iwait/iload handshake. Sets, ways and words per block are generic. Fills are multi-word, victims are chosen by true LRU, and a flush input clears every line.

---
 rtl/icache_assoc.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Brief    : Set-associative instruction cache, true-LRU victims, multi-word
//            line fills. Define ICACHE_STATS_EN to add hit/miss counters.
// Revision : 1.0
// ============================================================================
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        invalidate,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_OFF_B = $clog2(WORDS);
    localparam int c_CNT_W = (WORDS > 1) ? c_OFF_B : 1;
    localparam int c_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int c_TAG_W = 30 - c_OFF_B - c_IDX_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             r_state, w_next;
    logic [c_TAG_W-1:0] r_ftag;
    logic [c_IDX_W-1:0] r_fidx;
    logic [c_WAY_W-1:0] r_victim;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WAYS-1:0]    r_valid [SETS];
    logic [c_TAG_W-1:0] r_tag   [SETS][WAYS];
    logic [31:0]        r_data  [SETS][WAYS][WORDS];
    logic [31:0]        r_buf   [WORDS];

    logic [c_TAG_W-1:0] w_tag;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_CNT_W-1:0] w_off;
    logic               w_hit_any;
    logic [c_WAY_W-1:0] w_hit_way, w_victim, w_lru_victim;
    logic               w_miss, w_accept, w_fill_done, w_touch;
    logic [c_IDX_W-1:0] w_touch_idx;
    logic [c_WAY_W-1:0] w_touch_way;
    logic [31:0]        w_fill_addr;
    logic               w_unused;

    assign w_tag = imemaddr[31 -: c_TAG_W];
    assign w_idx = imemaddr[2 + c_OFF_B +: c_IDX_W];

    if (WORDS > 1) begin : g_multiword
        assign w_off       = imemaddr[2 +: c_OFF_B];
        assign w_fill_addr = {r_ftag, r_fidx, r_cnt, 2'b00};
        assign w_unused    = ^imemaddr[1:0];
    end else begin : g_oneword
        assign w_off       = '0;
        assign w_fill_addr = {r_ftag, r_fidx, 2'b00};
        assign w_unused    = ^{imemaddr[1:0], r_cnt};
    end

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins over the LRU way.
    always_comb begin
        w_victim = w_lru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_victim = c_WAY_W'(w);
        end
    end

    assign w_miss      = (r_state == IDLE) && imemREN && !invalidate && !w_hit_any;
    assign w_accept    = (r_state == FILL) && !invalidate && !iwait;
    assign w_fill_done = w_accept && (r_cnt == c_CNT_W'(WORDS - 1));
    assign w_touch     = ihit || w_fill_done;
    assign w_touch_idx = (r_state == FILL) ? r_fidx : w_idx;
    assign w_touch_way = (r_state == FILL) ? r_victim : w_hit_way;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        case (r_state)
            IDLE: begin
                if (imemREN && !invalidate && w_hit_any) begin
                    ihit     = 1'b1;
                    imemload = r_data[w_idx][w_hit_way][w_off];
                end
                if (w_miss) w_next = FILL;
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = w_fill_addr;
                if (invalidate || w_fill_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt    <= '0;
            r_ftag   <= '0;
            r_fidx   <= '0;
            r_victim <= '0;
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else begin
            if (w_miss) begin
                r_ftag   <= w_tag;
                r_fidx   <= w_idx;
                r_victim <= w_victim;
            end
            if ((r_state == FILL) && (invalidate || w_fill_done)) r_cnt <= '0;
            else if (w_accept)                                    r_cnt <= r_cnt + c_CNT_W'(1);
            if (invalidate) begin
                for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
            end else if (w_fill_done) begin
                r_valid[r_fidx][r_victim] <= 1'b1;
            end
        end
    end

    // The last word goes straight from iload into the array, bypassing the buffer.
    always_ff @(posedge CLK) begin
        if (w_accept) r_buf[r_cnt] <= iload;
        if (w_fill_done) begin
            r_tag[r_fidx][r_victim] <= r_ftag;
            for (int k = 0; k < WORDS; k++)
                r_data[r_fidx][r_victim][k] <= (k == WORDS - 1) ? iload : r_buf[k];
        end
    end

    if (WAYS > 1) begin : g_lru
        logic [c_WAY_W-1:0] r_age [SETS][WAYS];
        logic [c_WAY_W-1:0] w_ref_age;

        assign w_ref_age = r_age[w_touch_idx][w_touch_way];

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        r_age[s][w] <= c_WAY_W'(w);
            end else if (w_touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (c_WAY_W'(w) == w_touch_way)
                        r_age[w_touch_idx][w] <= '0;
                    else if (r_age[w_touch_idx][w] < w_ref_age)
                        r_age[w_touch_idx][w] <= r_age[w_touch_idx][w] + c_WAY_W'(1);
                end
            end
        end

        always_comb begin
            w_lru_victim = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w_idx][w] == c_WAY_W'(WAYS - 1)) w_lru_victim = c_WAY_W'(w);
            end
        end
    end else begin : g_direct
        assign w_lru_victim = '0;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit && (hit_count != '1))    hit_count  <= hit_count + 32'd1;
            if (w_miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
